pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control-unit FSM that sequences the program counter by driving its 2-bit select (PS) and its 32-bit operand (in).
- Runs each instruction through fetch handshake, execute/stall, then exactly one PC update cycle.
- Resolves trap, branch, halt and sequential advance with a fixed priority.
- Sits between the instruction-memory interface, decode/execute and program_counter.

Parameters:
- TRAP_VECTOR, 32'h0000_0004: absolute PC loaded on trap or fetch timeout.
- FETCH_TIMEOUT, 16: max FETCH cycles waiting for imem_ack before fetch error; 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_ack  input  1  instruction memory has data for the current PC
- stall  input  1  execute not ready to retire; hold in EXEC
- br_valid  input  1  branch/jump taken, sampled in EXEC
- br_rel  input  1  1 = relative (PC + br_target), 0 = absolute (br_target)
- br_target  input  32  branch target or two's-complement offset
- trap  input  1  level trap request
- halt  input  1  halt after current instruction
- resume  input  1  leave HALT
- imem_req  output  1  fetch request for the current PC
- instr_valid  output  1  one-cycle pulse: fetched instruction is valid
- fetch_err  output  1  one-cycle pulse on fetch timeout
- PS  output  2  program_counter select: 00 hold, 01 +1, 10 load, 11 add
- pc_in  output  32  program_counter operand
- state  output  3  FSM state, for debug

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; PS = 00; pc_in = 0.
  - imem_req, instr_valid, fetch_err = 0; timeout counter = 0.
  - All of the above take effect immediately, including mid-fetch or mid-UPDATE.
- State encoding: IDLE = 0, FETCH = 1, EXEC = 2, UPDATE = 3, HALT = 4.
- All outputs are registered.
- Outside UPDATE, PS = 00 and pc_in = 0, so the PC is held.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req = 1; the counter increments each cycle.
  - On imem_ack: next cycle instr_valid = 1 for one cycle, state = EXEC, counter cleared.
  - If FETCH_TIMEOUT != 0 and the counter reaches FETCH_TIMEOUT without ack: fetch_err pulses one cycle, then UPDATE with PS = 10, pc_in = TRAP_VECTOR.
  - imem_ack in any other state is ignored.
- EXEC:
  - If stall = 1: remain in EXEC; no other inputs are sampled.
  - If stall = 0, evaluate in priority order:
    1. trap = 1 → UPDATE with PS = 10, pc_in = TRAP_VECTOR.
    2. br_valid = 1 → UPDATE with PS = (br_rel ? 11 : 10), pc_in = br_target.
    3. halt = 1 → HALT; the PC stays on the halting instruction.
    4. Otherwise → UPDATE with PS = 01, pc_in = 0.
- UPDATE:
  - PS and pc_in are driven for exactly one cycle; the program counter commits on that cycle's closing edge.
  - Next state is FETCH, which fetches the new PC.
- HALT:
  - PS = 00, imem_req = 0.
  - trap = 1 → UPDATE to TRAP_VECTOR (trap beats resume).
  - Otherwise resume = 1 → UPDATE with PS = 01.
  - Otherwise remain in HALT.
- Throughput: with zero-wait memory (ack in the first FETCH cycle) and no stall, one instruction takes 4 cycles: FETCH, ack-seen/EXEC entry, EXEC, UPDATE.
- Arithmetic:
  - br_target is passed through unmodified; relative offsets are two's complement.
  - 32-bit wrap-around is performed by program_counter, not this block.
- Simultaneous inputs:
  - trap + br_valid + halt in EXEC → trap wins.
  - br_valid + halt → branch wins and halt is dropped; the source must reassert it.
  - stall masks everything, including trap.
- trap is level-sensitive. It is not latched in FETCH or IDLE; it is taken at the next EXEC or HALT evaluation.

Test Plan:
- Reset then run sequentially:
  - Release rst_n, ack on the 1st FETCH cycle, no stall.
  - Required: IDLE → FETCH → EXEC → UPDATE with PS = 01, repeating.
  - Required: PC goes 0x800, 0x801, 0x802; instr_valid pulses once per instruction.
- Relative branch:
  - In EXEC, br_valid = 1, br_rel = 1, br_target = 32'hFFFF_FFFC.
  - Required: UPDATE drives PS = 11, pc_in = FFFF_FFFC; PC goes 0x802 → 0x7FE.
- Priority and stall:
  - Hold stall = 1 for 5 cycles with trap, br_valid and halt all = 1.
  - Required while stalled: state stays EXEC, PS = 00.
  - Then drop stall. Required: PS = 10, pc_in = 0x4; PC becomes 0x4.
- Fetch timeout:
  - Never assert imem_ack.
  - Required: after 16 FETCH cycles, fetch_err pulses exactly once, then PS = 10, pc_in = 0x4, then FETCH again.
  - Repeat with FETCH_TIMEOUT = 0. Required: imem_req stays high indefinitely and fetch_err is never asserted.
- Halt and resume:
  - halt in EXEC with PC = 0x810.
  - Required: HALT with PC held at 0x810 for 20 cycles and imem_req = 0.
  - Then resume = 1 and trap = 1 in the same cycle. Required: trap wins, PC = 0x4.
- Async reset mid-UPDATE:
  - Pull rst_n low while PS = 11.
  - Required: PS = 00, imem_req = 0 and state = IDLE before the next clk edge; PC returns to 0x800.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Control-unit FSM that walks each instruction through a fetch handshake,
// an execute/stall phase and exactly one program-counter update cycle. It
// drives the program_counter select (PS) and operand (pc_in), resolving trap,
// branch, halt and sequential advance with a fixed priority.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_ack     instruction memory has data for the current PC
//   stall        execute not ready to retire; hold in EXEC
//   br_valid     branch/jump taken, sampled in EXEC
//   br_rel       1 = PC + br_target, 0 = absolute br_target
//   br_target    branch target or two's-complement offset
//   trap         level trap request
//   halt         halt after current instruction
//   resume       leave HALT
//   imem_req     fetch request for the current PC
//   instr_valid  one-cycle pulse: fetched instruction is valid
//   fetch_err    one-cycle pulse on fetch timeout
//   PS           program_counter select: 00 hold, 01 +1, 10 load, 11 add
//   pc_in        program_counter operand
//   state        FSM state (IDLE 0, FETCH 1, EXEC 2, UPDATE 3, HALT 4)
module pc_sequencer #(
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0004,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_rel,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        resume,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [1:0]  PS,
  output logic [31:0] pc_in,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    UPDATE = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_ADD  = 2'b11;

  localparam bit         TIMEOUT_EN = (FETCH_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT    = 8'(FETCH_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        req_d, iv_d, err_d;
  logic [1:0]  ps_d;
  logic [31:0] pc_in_d;

  assign state = state_q;

  // Next-state and next-output logic. Every output is computed here for the
  // state being entered and then registered, so the outputs seen in a cycle
  // always belong to the registered state of that cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = 1'b0;
    iv_d    = 1'b0;
    err_d   = 1'b0;
    ps_d    = PS_HOLD;
    pc_in_d = '0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        wait_d  = '0;
      end

      FETCH: begin
        // A raised fetch_err marks the error cycle that follows a timeout;
        // the request is already dropped, so the trap-vector update follows.
        if (fetch_err) begin
          state_d = UPDATE;
          ps_d    = PS_LOAD;
          pc_in_d = TRAP_VECTOR;
          wait_d  = '0;
        end else if (imem_ack) begin
          state_d = EXEC;
          iv_d    = 1'b1;
          wait_d  = '0;
        end else if (TIMEOUT_EN && (wait_q + 8'd1 == TIMEOUT)) begin
          err_d  = 1'b1;
          wait_d = TIMEOUT;
        end else begin
          req_d = 1'b1;
          if (TIMEOUT_EN) wait_d = wait_q + 8'd1;
        end
      end

      EXEC: begin
        // The entry cycle (instr_valid high) hands the instruction to
        // decode/execute; its verdict is sampled from the next cycle on.
        if (!instr_valid && !stall) begin
          if (trap) begin
            state_d = UPDATE;
            ps_d    = PS_LOAD;
            pc_in_d = TRAP_VECTOR;
          end else if (br_valid) begin
            state_d = UPDATE;
            ps_d    = br_rel ? PS_ADD : PS_LOAD;
            pc_in_d = br_target;
          end else if (halt) begin
            state_d = HALT;
          end else begin
            state_d = UPDATE;
            ps_d    = PS_INC;
          end
        end
      end

      UPDATE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        wait_d  = '0;
      end

      HALT: begin
        if (trap) begin
          state_d = UPDATE;
          ps_d    = PS_LOAD;
          pc_in_d = TRAP_VECTOR;
        end else if (resume) begin
          state_d = UPDATE;
          ps_d    = PS_INC;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately so the
  // program counter is held even if reset lands mid-update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      PS          <= PS_HOLD;
      pc_in       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      imem_req    <= req_d;
      instr_valid <= iv_d;
      fetch_err   <= err_d;
      PS          <= ps_d;
      pc_in       <= pc_in_d;
    end
  end

endmodule
